alu_arbiter: RTL and testbench



---
 rtl/alu_arb_pkg.sv | 19 +
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_addsub.sv | 32 +++
 rtl/rr_arb2.sv | 20 ++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and constants for the two-requester ALU arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef logic req_id_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between the requesters and the shared ALU
// ALU_OVF_EN adds the o_rsp_v overflow flag.
interface alu_arbiter_if #(
  parameter int DW = 16
);

  logic [1:0]    i_req_valid;
  logic [1:0]    o_req_ready;
  logic [1:0]    i_req_op_sel;
  logic [DW-1:0] i_req_a0;
  logic [DW-1:0] i_req_b0;
  logic [DW-1:0] i_req_a1;
  logic [DW-1:0] i_req_b1;
  logic [1:0]    o_rsp_valid;
  logic [1:0]    i_rsp_ready;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_n;
  logic          o_rsp_z;
`ifdef ALU_OVF_EN
  logic          o_rsp_v;

  modport master (
    output i_req_valid, i_req_op_sel, i_req_a0, i_req_b0, i_req_a1, i_req_b1, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_n, o_rsp_z, o_rsp_v
  );

  modport slave (
    input  i_req_valid, i_req_op_sel, i_req_a0, i_req_b0, i_req_a1, i_req_b1, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_n, o_rsp_z, o_rsp_v
  );
`else
  modport master (
    output i_req_valid, i_req_op_sel, i_req_a0, i_req_b0, i_req_a1, i_req_b1, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_n, o_rsp_z
  );

  modport slave (
    input  i_req_valid, i_req_op_sel, i_req_a0, i_req_b0, i_req_a1, i_req_b1, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_n, o_rsp_z
  );
`endif

endinterface

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - combinational DW-bit add/sub with N/Z flags
// ALU_OVF_EN adds the signed-overflow output v_o.
module alu_addsub
  import alu_arb_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          op_i,
  output logic [DW-1:0] res_o,
  output logic          n_o,
  output logic          z_o
`ifdef ALU_OVF_EN
  ,
  output logic          v_o
`endif
);

  logic [DW-1:0] b_eff;

  // Subtraction reuses the adder as a + ~b + 1; the carry-out is dropped.
  assign b_eff = (op_i == OP_SUB) ? ~b_i : b_i;
  assign res_o = a_i + b_eff + {{(DW-1){1'b0}}, op_i};
  assign n_o   = res_o[DW-1];
  assign z_o   = (res_o == '0);

`ifdef ALU_OVF_EN
  assign v_o = (a_i[DW-1] == b_eff[DW-1]) & (res_o[DW-1] != a_i[DW-1]);
`endif

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant; ptr_i names the requester favoured on contention
module rr_arb2
  import alu_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_id_t    ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = id_onehot(ptr_i);
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one add/sub ALU between two requesters
// ALU_OVF_EN enables the registered signed-overflow flag o_rsp_v.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW = 16
) (
  input logic          clk,
  input logic          reset,
  alu_arbiter_if.slave bus
);

  state_e        state_q;
  req_id_t       rr_ptr_q;
  req_id_t       id_q;
  logic          op_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [1:0]    rsp_valid_q;
  logic [DW-1:0] data_q;
  logic          n_q;
  logic          z_q;

  logic [1:0]    grant;
  logic          req_hs;
  req_id_t       id_d;
  logic          op_d;
  logic [DW-1:0] a_d;
  logic [DW-1:0] b_d;

  logic [DW-1:0] alu_res;
  logic          alu_n;
  logic          alu_z;

  rr_arb2 u_rr_arb2 (
    .valid_i (bus.i_req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant)
  );

  assign bus.o_req_ready = (state_q == IDLE) ? grant : 2'b00;
  assign req_hs          = |bus.o_req_ready;

  always_comb begin
    id_d = req_id_t'(grant[1]);
    op_d = bus.i_req_op_sel[id_d];
    a_d  = id_d ? bus.i_req_a1 : bus.i_req_a0;
    b_d  = id_d ? bus.i_req_b1 : bus.i_req_b0;
  end

`ifdef ALU_OVF_EN
  logic alu_v;
  logic v_q;

  alu_addsub #(.DW(DW)) u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (alu_res),
    .n_o   (alu_n),
    .z_o   (alu_z),
    .v_o   (alu_v)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= 1'b0;
    end else if (state_q == EXEC) begin
      v_q <= alu_v;
    end
  end

  assign bus.o_rsp_v = v_q;
`else
  alu_addsub #(.DW(DW)) u_alu (
    .a_i   (a_q),
    .b_i   (b_q),
    .op_i  (op_q),
    .res_o (alu_res),
    .n_o   (alu_n),
    .z_o   (alu_z)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 2'b00;
      data_q      <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_hs) begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            rr_ptr_q <= ~id_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          data_q      <= alu_res;
          n_q         <= alu_n;
          z_q         <= alu_z;
          rsp_valid_q <= id_onehot(id_q);
          state_q     <= RESP;
        end
        RESP: begin
          // Only the owner's ready retires the response.
          if (bus.i_rsp_ready[id_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_data  = data_q;
  assign bus.o_rsp_n     = n_q;
  assign bus.o_rsp_z     = z_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against an arithmetic model
module tb_alu_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   exp_ptr;

  alu_arbiter_if #(.DW(16)) bus ();

  alu_arbiter #(.DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int g);
    return (g != 0) ? 2'b10 : 2'b01;
  endfunction

  // Returns {v, n, z, result} from signed integer arithmetic.
  function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
    int sa, sb, s;
    logic [15:0] r;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = op ? (sa - sb) : (sa + sb);
    r  = s[15:0];
    v  = (s > 32767) || (s < -32768);
    return {v, r[15], (r == 16'h0000), r};
  endfunction

  task automatic serve(input logic [1:0] pend_in, input logic [15:0] a0, input logic [15:0] b0,
                       input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] ops,
                       input int bp);
    logic [1:0]  pend;
    logic [18:0] m;
    int          g;
    pend = pend_in;
    while (pend != 2'b00) begin
      @(negedge clk);
      bus.i_req_valid  = pend;
      bus.i_req_a0     = a0;
      bus.i_req_b0     = b0;
      bus.i_req_a1     = a1;
      bus.i_req_b1     = b1;
      bus.i_req_op_sel = ops;
      #1;
      if (pend == 2'b11) g = exp_ptr;
      else g = pend[1] ? 1 : 0;
      chk("req_ready", 32'(bus.o_req_ready), 32'(oh(g)));
      m = (g != 0) ? model(a1, b1, ops[1]) : model(a0, b0, ops[0]);

      @(negedge clk);
      pend[g] = 1'b0;
      bus.i_req_valid = pend;
      #1;
      chk("ready_in_exec", 32'(bus.o_req_ready), 32'd0);
      chk("rsp_valid_exec", 32'(bus.o_rsp_valid), 32'd0);

      @(negedge clk);
      #1;
      chk("rsp_valid", 32'(bus.o_rsp_valid), 32'(oh(g)));
      chk("rsp_data", 32'(bus.o_rsp_data), 32'(m[15:0]));
      chk("rsp_z", 32'(bus.o_rsp_z), 32'(m[16]));
      chk("rsp_n", 32'(bus.o_rsp_n), 32'(m[17]));
`ifdef ALU_OVF_EN
      chk("rsp_v", 32'(bus.o_rsp_v), 32'(m[18]));
`endif

      for (int i = 0; i < bp; i++) begin
        bus.i_rsp_ready = ($urandom_range(0, 1) != 0) ? oh(1 - g) : 2'b00;
        @(negedge clk);
        #1;
        chk("bp_valid", 32'(bus.o_rsp_valid), 32'(oh(g)));
        chk("bp_data", 32'(bus.o_rsp_data), 32'(m[15:0]));
        chk("bp_ready", 32'(bus.o_req_ready), 32'd0);
      end

      bus.i_rsp_ready = oh(g) | (($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00);
      @(negedge clk);
      bus.i_rsp_ready = 2'b00;
      bus.i_req_valid = 2'b00;
      #1;
      chk("rsp_cleared", 32'(bus.o_rsp_valid), 32'd0);
      chk("data_hold", 32'(bus.o_rsp_data), 32'(m[15:0]));
      exp_ptr = 1 - g;
    end
  endtask

  initial begin
    logic [15:0] ra0, rb0, ra1, rb1;
    n_checks = 0;
    n_fail   = 0;
    exp_ptr  = 0;
    reset    = 1'b1;
    bus.i_req_valid  = 2'b00;
    bus.i_req_op_sel = 2'b00;
    bus.i_req_a0     = 16'h0;
    bus.i_req_b0     = 16'h0;
    bus.i_req_a1     = 16'h0;
    bus.i_req_b1     = 16'h0;
    bus.i_rsp_ready  = 2'b00;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(bus.o_req_ready), 32'd0);
    chk("reset_data", 32'(bus.o_rsp_data), 32'd0);
    chk("reset_n", 32'(bus.o_rsp_n), 32'd0);
    chk("reset_z", 32'(bus.o_rsp_z), 32'd0);
`ifdef ALU_OVF_EN
    chk("reset_v", 32'(bus.o_rsp_v), 32'd0);
`endif

    serve(2'b01, 16'h0005, 16'h0003, 16'h0, 16'h0, 2'b00, 0);
    serve(2'b10, 16'h0, 16'h0, 16'h1234, 16'h1234, 2'b10, 2);
    serve(2'b10, 16'h0, 16'h0, 16'h0001, 16'h0002, 2'b10, 0);

    // Contention directly after reset: requester 0 must win both rounds.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ptr = 0;
    serve(2'b11, 16'h0001, 16'h0002, 16'h0005, 16'h0001, 2'b10, 1);
    serve(2'b11, 16'h0001, 16'h0002, 16'h0005, 16'h0001, 2'b10, 0);

    serve(2'b01, 16'h0010, 16'h0001, 16'h0, 16'h0, 2'b00, 5);

    // Asynchronous reset while the operation is in EXEC.
    @(negedge clk);
    bus.i_req_valid  = 2'b01;
    bus.i_req_a0     = 16'h00F0;
    bus.i_req_b0     = 16'h000F;
    bus.i_req_op_sel = 2'b00;
    @(negedge clk);
    bus.i_req_valid = 2'b00;
    reset = 1'b1;
    #1;
    chk("rst_exec_valid", 32'(bus.o_rsp_valid), 32'd0);
    chk("rst_exec_data", 32'(bus.o_rsp_data), 32'd0);
    chk("rst_exec_ready", 32'(bus.o_req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_exec_hold", 32'(bus.o_rsp_valid), 32'd0);
    reset = 1'b0;
    exp_ptr = 0;
    serve(2'b10, 16'h0, 16'h0, 16'h4000, 16'h0001, 2'b00, 1);

`ifdef ALU_OVF_EN
    serve(2'b01, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 2'b00, 0);
    chk("ovf_add_v", 32'(bus.o_rsp_v), 32'd1);
    serve(2'b01, 16'h8000, 16'h0001, 16'h0, 16'h0, 2'b01, 0);
    chk("ovf_sub_v", 32'(bus.o_rsp_v), 32'd1);
    serve(2'b01, 16'h0002, 16'h0001, 16'h0, 16'h0, 2'b01, 0);
    chk("no_ovf_v", 32'(bus.o_rsp_v), 32'd0);
`endif

    for (int it = 0; it < 40; it++) begin
      ra0 = 16'($urandom);
      rb0 = 16'($urandom);
      ra1 = 16'($urandom);
      rb1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb0 = ra0;
      if ($urandom_range(0, 3) == 0) rb1 = ra1;
      serve(2'($urandom_range(1, 3)), ra0, rb0, ra1, rb1, 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
